// File: rtl/mem_access_ctrl.sv
// Multi-cycle load/store sequencer for the memory stage. It accepts one memory op, checks it,
// runs the bus request and read-data handshakes, and returns the result on a valid/ready port.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [11:0] req_code,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_rt,

    output logic [11:0] lane_code,
    output logic [1:0]  lane_ea,
    output logic [31:0] lane_mem_in,
    output logic [31:0] lane_reg_in,
    input  logic [31:0] lane_load_data,
    input  logic [31:0] lane_store_data,
    input  logic [3:0]  lane_strb,

    output logic [31:0] Address,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Write_data,
    output logic [3:0]  Write_strb,
    input  logic        Mem_Req_Ack,
    input  logic [31:0] Read_data,
    input  logic        Read_data_Valid,
    output logic        Read_data_Ready,

    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [1:0]  resp_err
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StRdw,
        StResp
    } state_e;

    localparam logic [1:0] ErrOk      = 2'b00;
    localparam logic [1:0] ErrAlign   = 2'b01;
    localparam logic [1:0] ErrCode    = 2'b10;
    localparam logic [1:0] ErrTimeout = 2'b11;

    localparam bit               TimeoutEn = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CntLast   = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [11:0]       code_q, code_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       rt_q, rt_d;
    logic [31:0]       mem_q, mem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        err_q, err_d;

    logic code_onehot;
    logic need_word_align;
    logic need_half_align;
    logic misaligned;
    logic is_load;
    logic timeout_hit;

    // Legality is judged on the incoming request so the error path never touches the bus.
    assign code_onehot     = (req_code != 12'd0) && ((req_code & (req_code - 12'd1)) == 12'd0);
    assign need_word_align = req_code[0] | req_code[7];
    assign need_half_align = req_code[3] | req_code[4] | req_code[9];
    assign misaligned      = (need_word_align && (req_addr[1:0] != 2'b00)) ||
                             (need_half_align && req_addr[0]);

    assign is_load     = |code_q[6:0];
    assign timeout_hit = TimeoutEn && (cnt_q == CntLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            code_q  <= '0;
            addr_q  <= '0;
            rt_q    <= '0;
            mem_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            addr_q  <= addr_d;
            rt_q    <= rt_d;
            mem_q   <= mem_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        code_d          = code_q;
        addr_d          = addr_q;
        rt_d            = rt_q;
        mem_d           = mem_q;
        cnt_d           = cnt_q;
        err_d           = err_q;
        req_ready       = 1'b0;
        MemRead         = 1'b0;
        MemWrite        = 1'b0;
        Read_data_Ready = 1'b0;
        resp_valid      = 1'b0;

        case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    code_d = req_code;
                    addr_d = req_addr;
                    rt_d   = req_rt;
                    mem_d  = '0;
                    cnt_d  = '0;
                    err_d  = ErrOk;
                    if (!code_onehot) begin
                        state_d = StResp;
                        err_d   = ErrCode;
                    end else if (misaligned) begin
                        state_d = StResp;
                        err_d   = ErrAlign;
                    end else begin
                        state_d = StReq;
                    end
                end
            end

            StReq: begin
                MemRead  = is_load;
                MemWrite = !is_load;
                // A handshake landing on the last counted cycle still wins over the timeout.
                if (Mem_Req_Ack) begin
                    cnt_d   = '0;
                    state_d = is_load ? StRdw : StResp;
                end else if (timeout_hit) begin
                    state_d = StResp;
                    err_d   = ErrTimeout;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            StRdw: begin
                Read_data_Ready = 1'b1;
                if (Read_data_Valid) begin
                    mem_d   = Read_data;
                    state_d = StResp;
                end else if (timeout_hit) begin
                    state_d = StResp;
                    err_d   = ErrTimeout;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            StResp: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // State already idles during reset; ready must still read low.
        if (rst) begin
            req_ready = 1'b0;
        end
    end

    assign lane_code   = code_q;
    assign lane_ea     = addr_q[1:0];
    assign lane_mem_in = mem_q;
    assign lane_reg_in = rt_q;

    assign Address    = {addr_q[31:2], 2'b00};
    assign Write_data = rst ? 32'd0 : lane_store_data;
    assign Write_strb = rst ? 4'd0 : lane_strb;

    assign resp_data = ((state_q == StResp) && (err_q == ErrOk) && is_load) ? lane_load_data
                                                                            : 32'd0;
    assign resp_err  = (state_q == StResp) ? err_q : 2'b00;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed ops with hand-computed results, a behavioural
// byte-lane unit and a memory responder with programmable ack/valid delays.
module tb_mem_access_ctrl;

    localparam int unsigned TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [11:0] req_code = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_rt = '0;
    logic [11:0] lane_code;
    logic [1:0]  lane_ea;
    logic [31:0] lane_mem_in;
    logic [31:0] lane_reg_in;
    logic [31:0] lane_load_data;
    logic [31:0] lane_store_data;
    logic [3:0]  lane_strb;
    logic [31:0] Address;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        Mem_Req_Ack = 1'b0;
    logic [31:0] Read_data = '0;
    logic        Read_data_Valid = 1'b0;
    logic        Read_data_Ready;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_data;
    logic [1:0]  resp_err;

    mem_access_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_code        (req_code),
        .req_addr        (req_addr),
        .req_rt          (req_rt),
        .lane_code       (lane_code),
        .lane_ea         (lane_ea),
        .lane_mem_in     (lane_mem_in),
        .lane_reg_in     (lane_reg_in),
        .lane_load_data  (lane_load_data),
        .lane_store_data (lane_store_data),
        .lane_strb       (lane_strb),
        .Address         (Address),
        .MemRead         (MemRead),
        .MemWrite        (MemWrite),
        .Write_data      (Write_data),
        .Write_strb      (Write_strb),
        .Mem_Req_Ack     (Mem_Req_Ack),
        .Read_data       (Read_data),
        .Read_data_Valid (Read_data_Valid),
        .Read_data_Ready (Read_data_Ready),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_data       (resp_data),
        .resp_err        (resp_err)
    );

    initial forever #5 clk = ~clk;

    // Little-endian MIPS byte-lane unit.
    logic [31:0] shifted;
    always_comb begin
        lane_load_data  = '0;
        lane_store_data = '0;
        lane_strb       = '0;
        shifted         = lane_mem_in >> {lane_ea, 3'b000};
        case (lane_code)
            12'h001: lane_load_data = lane_mem_in;
            12'h002: lane_load_data = {{24{shifted[7]}}, shifted[7:0]};
            12'h004: lane_load_data = {24'd0, shifted[7:0]};
            12'h008: lane_load_data = {{16{shifted[15]}}, shifted[15:0]};
            12'h010: lane_load_data = {16'd0, shifted[15:0]};
            12'h020: case (lane_ea)
                2'd0: lane_load_data = {lane_mem_in[7:0], lane_reg_in[23:0]};
                2'd1: lane_load_data = {lane_mem_in[15:0], lane_reg_in[15:0]};
                2'd2: lane_load_data = {lane_mem_in[23:0], lane_reg_in[7:0]};
                default: lane_load_data = lane_mem_in;
            endcase
            12'h040: case (lane_ea)
                2'd0: lane_load_data = lane_mem_in;
                2'd1: lane_load_data = {lane_reg_in[31:24], lane_mem_in[31:8]};
                2'd2: lane_load_data = {lane_reg_in[31:16], lane_mem_in[31:16]};
                default: lane_load_data = {lane_reg_in[31:8], lane_mem_in[31:24]};
            endcase
            12'h080: begin
                lane_store_data = lane_reg_in;
                lane_strb       = 4'b1111;
            end
            12'h100: begin
                lane_store_data = lane_reg_in << {lane_ea, 3'b000};
                lane_strb       = 4'b0001 << lane_ea;
            end
            12'h200: begin
                lane_store_data = lane_reg_in << {lane_ea, 3'b000};
                lane_strb       = 4'b0011 << lane_ea;
            end
            12'h400: begin
                lane_store_data = lane_reg_in >> {~lane_ea, 3'b000};
                lane_strb       = 4'b1111 >> ~lane_ea;
            end
            12'h800: begin
                lane_store_data = lane_reg_in << {lane_ea, 3'b000};
                lane_strb       = 4'b1111 << lane_ea;
            end
            default: ;
        endcase
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Memory responder knobs; -1 means never respond.
    int          ack_wait   = 0;
    int          valid_wait = 0;
    logic [31:0] rd_word    = '0;
    int          rd_cycles  = 0;
    int          wr_cycles  = 0;
    logic [31:0] last_addr  = '0;
    logic [31:0] last_wdata = '0;
    logic [3:0]  last_strb  = '0;

    initial begin
        int req_cyc = 0;
        int rdv_cyc = 0;
        forever begin
            @(negedge clk);
            Read_data = rd_word;
            if (MemRead || MemWrite) begin
                if (MemRead) rd_cycles++;
                if (MemWrite) wr_cycles++;
                if (req_cyc == 0) begin
                    last_addr  = Address;
                    last_wdata = Write_data;
                    last_strb  = Write_strb;
                end
                Mem_Req_Ack = (ack_wait >= 0) && (req_cyc == ack_wait);
                req_cyc++;
            end else begin
                Mem_Req_Ack = 1'b0;
                req_cyc     = 0;
            end
            if (Read_data_Ready) begin
                Read_data_Valid = (valid_wait >= 0) && (rdv_cyc == valid_wait);
                rdv_cyc++;
            end else begin
                Read_data_Valid = 1'b0;
                rdv_cyc         = 0;
            end
        end
    end

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic [1:0]  err;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   done_cnt = 0;

    // Monitor: latency is counted from the accept edge to the first resp_valid cycle.
    initial begin
        int   ncyc = 0;
        int   acc_cyc = 0;
        int   lat = 0;
        bit   seen_valid = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            ncyc++;
            if (rst) begin
                seen_valid = 1'b0;
            end else begin
                if (req_valid && req_ready) acc_cyc = ncyc;
                if (resp_valid && !seen_valid) begin
                    seen_valid = 1'b1;
                    lat        = ncyc - acc_cyc;
                end
                if (resp_valid && resp_ready) begin
                    seen_valid = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_resp: got data 0x%08h err %0d, expected none",
                                 resp_data, resp_err);
                    end else begin
                        e = exp_q.pop_front();
                        check({e.tag, "/data"}, resp_data, e.data);
                        check({e.tag, "/err"}, 32'(resp_err), 32'(e.err));
                        check({e.tag, "/latency"}, 32'(lat), 32'(e.lat));
                    end
                    done_cnt++;
                end
            end
        end
    end

    task automatic start(input logic [11:0] code, input logic [31:0] addr, input logic [31:0] rt,
                         input int aw, input int vw, input logic [31:0] rw);
        int n;
        ack_wait   = aw;
        valid_wait = vw;
        rd_word    = rw;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_code  = code;
        req_addr  = addr;
        req_rt    = rt;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) check("req_accept", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "/resp_seen"}, 32'(done_cnt), 32'(target));
    endtask

    task automatic txn(input string tag, input logic [11:0] code, input logic [31:0] addr,
                       input logic [31:0] rt, input int aw, input int vw, input logic [31:0] rw,
                       input logic [31:0] exp_data, input logic [1:0] exp_err, input int exp_lat,
                       input int exp_rd, input int exp_wr);
        int d0, r0, w0;
        d0 = done_cnt;
        r0 = rd_cycles;
        w0 = wr_cycles;
        exp_q.push_back('{tag, exp_data, exp_err, exp_lat});
        start(code, addr, rt, aw, vw, rw);
        wait_done(tag, d0 + 1);
        @(posedge clk); #1;
        check({tag, "/read_cycles"}, 32'(rd_cycles - r0), 32'(exp_rd));
        check({tag, "/write_cycles"}, 32'(wr_cycles - w0), 32'(exp_wr));
    endtask

    initial begin
        int n;
        int d0;
        #1;
        check("reset/req_ready", 32'(req_ready), 32'd0);
        check("reset/resp_valid", 32'(resp_valid), 32'd0);
        check("reset/address", Address, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("idle/req_ready", 32'(req_ready), 32'd1);

        txn("sw_0x100", 12'h080, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0,
            32'h0, 2'b00, 2, 0, 1);
        check("sw_0x100/address", last_addr, 32'h100);
        check("sw_0x100/strb", 32'(last_strb), 32'hF);
        check("sw_0x100/wdata", last_wdata, 32'hDEADBEEF);

        txn("lb_0x203", 12'h002, 32'h203, 32'h0, 3, 2, 32'h80FFFFFF,
            32'hFFFFFF80, 2'b00, 8, 4, 0);
        check("lb_0x203/address", last_addr, 32'h200);

        txn("lh_0x301", 12'h008, 32'h301, 32'h0, 0, 0, 32'h0, 32'h0, 2'b01, 1, 0, 0);
        txn("sw_0x302", 12'h080, 32'h302, 32'h0, 0, 0, 32'h0, 32'h0, 2'b01, 1, 0, 0);
        txn("lwl_0x301", 12'h020, 32'h301, 32'h11223344, 0, 0, 32'hAABBCCDD,
            32'hCCDD3344, 2'b00, 3, 1, 0);
        txn("code_0x003", 12'h003, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 2'b10, 1, 0, 0);
        txn("code_0x000", 12'h000, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 2'b10, 1, 0, 0);

        txn("lw_timeout", 12'h001, 32'h500, 32'h0, -1, 0, 32'h0, 32'h0, 2'b11, 5, 4, 0);
        txn("lw_ack_last", 12'h001, 32'h504, 32'h0, 3, 0, 32'h12345678,
            32'h12345678, 2'b00, 6, 4, 0);

        // lwr with the consumer stalling: the response must hold steady.
        d0 = done_cnt;
        resp_ready = 1'b0;
        exp_q.push_back('{"lwr_0x401", 32'h11AABBCC, 2'b00, 3});
        start(12'h040, 32'h401, 32'h11223344, 0, 0, 32'hAABBCCDD);
        n = 0;
        while (!resp_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("lwr_0x401/hold_valid", 32'(resp_valid), 32'd1);
            check("lwr_0x401/hold_data", resp_data, 32'h11AABBCC);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        wait_done("lwr_0x401", d0 + 1);

        // Reset pulse while waiting for read data.
        start(12'h001, 32'h600, 32'h0, 0, -1, 32'h0);
        n = 0;
        while (!Read_data_Ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_mid/in_rdw", 32'(Read_data_Ready), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid/req_ready", 32'(req_ready), 32'd0);
        check("rst_mid/rd_ready", 32'(Read_data_Ready), 32'd0);
        check("rst_mid/mem_read", 32'(MemRead), 32'd0);
        check("rst_mid/address", Address, 32'd0);
        check("rst_mid/lane_code", 32'(lane_code), 32'd0);
        check("rst_mid/resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_mid/idle_ready", 32'(req_ready), 32'd1);

        txn("sb_0x701", 12'h100, 32'h701, 32'h000000AB, 0, 0, 32'h0,
            32'h0, 2'b00, 2, 0, 1);
        check("sb_0x701/strb", 32'(last_strb), 32'h2);
        check("sb_0x701/wdata", last_wdata, 32'h0000AB00);
        check("sb_0x701/address", last_addr, 32'h700);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
